// File: rtl/lfs_pkg.sv
// Shared types and constants for the per-line SDRAM read scheduler.
// FACTOR_MIN/ONE_Q17 matter only when LFS_VZOOM_EN is defined.
package lfs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FRAME_INIT,
        WAIT_HS,
        LOAD,
        STEP
    } lfs_state_t;

    localparam logic [7:0] FACTOR_MIN = 8'h40;
    localparam logic [8:0] ONE_Q17    = 9'd128;

    // Zoom below 0.5 would need more than two source advances per line.
    function automatic logic [7:0] clamp_factor(input logic [7:0] f);
        return (f < FACTOR_MIN) ? FACTOR_MIN : f;
    endfunction

endpackage

// File: rtl/lfs_edge_sync.sv
// Three-flop synchroniser with falling-edge detect for active-low VGA syncs.
// Resets to all ones so a reset release never fakes an edge.
module lfs_edge_sync (
    input  logic clk_vga,
    input  logic dly_rstn,
    input  logic i_sig,
    output logic o_fall
);

    logic [2:0] r_d;

    always_ff @(posedge clk_vga or negedge dly_rstn) begin
        if (!dly_rstn) r_d <= 3'b111;
        else           r_d <= {r_d[1:0], i_sig};
    end

    assign o_fall = !r_d[1] && r_d[2];

endmodule

// File: rtl/line_fetch_scheduler.sv
// Per-line read-FIFO load sequencer for the photo display path (clk_vga domain).
// Define LFS_VZOOM_EN to enable the vertical zoom accumulator; otherwise one source line per output line.
module line_fetch_scheduler
    import lfs_pkg::*;
#(
    parameter int HOR_SIZE  = 800,
    parameter int VER_SIZE  = 480,
    parameter int HOR_PITCH = 160,
    parameter int ADDR_W    = 23
) (
    input  logic              clk_vga,
    input  logic              dly_rstn,
    input  logic              i_vs,
    input  logic              i_hs,
    input  logic [7:0]        i_scale_factor,
    input  logic [9:0]        i_x_offset,
    input  logic [8:0]        i_y_offset,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_load,
    output logic              o_frame_start,
    output logic [8:0]        o_src_line,
    output logic              o_line_active,
    output logic              o_hs_overrun
);

    localparam int                LINE_W      = $clog2(VER_SIZE + 1);
    localparam logic [ADDR_W-1:0] HOR_SIZE_A  = ADDR_W'(HOR_SIZE);
    localparam logic [ADDR_W-1:0] HOR_PITCH_A = ADDR_W'(HOR_PITCH);
    localparam logic [8:0]        SRC_LAST    = 9'(VER_SIZE - 1);
    localparam logic [LINE_W-1:0] LINES       = LINE_W'(VER_SIZE);

    function automatic logic [8:0] clamp_src(input logic [8:0] y);
        return (y > SRC_LAST) ? SRC_LAST : y;
    endfunction

    lfs_state_t        r_state;
    logic [ADDR_W-1:0] r_row;
    logic [8:0]        r_src_line;
    logic [LINE_W-1:0] r_out_line;
    logic              r_hs_pend;

    logic              w_vs_fall;
    logic              w_hs_fall;
    logic              w_adv_req;
    logic              w_step_done;
    logic              w_can_adv;
    logic              w_adv;
    logic [ADDR_W-1:0] w_row_init;
    logic              w_unused_xlo;

    lfs_edge_sync u_vs_sync (
        .clk_vga  (clk_vga),
        .dly_rstn (dly_rstn),
        .i_sig    (i_vs),
        .o_fall   (w_vs_fall)
    );

    lfs_edge_sync u_hs_sync (
        .clk_vga  (clk_vga),
        .dly_rstn (dly_rstn),
        .i_sig    (i_hs),
        .o_fall   (w_hs_fall)
    );

    assign w_row_init = i_base_addr
                      + HOR_PITCH_A * ADDR_W'(i_x_offset[9:7])
                      + HOR_SIZE_A  * ADDR_W'(i_y_offset);

    // x_offset below one pitch unit is handled downstream, not here
    assign w_unused_xlo = ^i_x_offset[6:0];

`ifdef LFS_VZOOM_EN
    logic [7:0] r_f;
    logic [8:0] r_acc;

    assign w_adv_req   = (r_acc >= {1'b0, r_f});
    assign w_step_done = !w_adv_req;
`else
    logic w_unused_scale;

    assign w_unused_scale = ^i_scale_factor;
    assign w_adv_req      = 1'b1;
    assign w_step_done    = 1'b1;
`endif

    // r_src_line mirrors y_offset + src, so it doubles as the saturation test
    assign w_can_adv  = (r_src_line < SRC_LAST);
    assign w_adv      = (r_state == STEP) && w_adv_req;
    assign o_src_line = r_src_line;

    always_ff @(posedge clk_vga or negedge dly_rstn) begin
        if (!dly_rstn) begin
            r_state       <= IDLE;
            r_hs_pend     <= 1'b0;
            r_out_line    <= '0;
            r_src_line    <= '0;
            o_rd_addr     <= '0;
            o_rd_load     <= 1'b0;
            o_frame_start <= 1'b0;
            o_line_active <= 1'b0;
            o_hs_overrun  <= 1'b0;
        end else begin
            o_rd_load     <= 1'b0;
            o_frame_start <= 1'b0;
            if (w_vs_fall) begin
                r_state       <= FRAME_INIT;
                r_hs_pend     <= 1'b0;
                o_frame_start <= 1'b1;
                o_hs_overrun  <= 1'b0;
            end else begin
                // Between frames HS keeps running through blanking and is ignored
                if (w_hs_fall && (r_state == FRAME_INIT || r_state == LOAD || r_state == STEP)) begin
                    if (r_hs_pend) o_hs_overrun <= 1'b1;
                    else           r_hs_pend    <= 1'b1;
                end
                case (r_state)
                    FRAME_INIT: begin
                        r_out_line    <= '0;
                        r_src_line    <= clamp_src(i_y_offset);
                        o_line_active <= 1'b1;
                        r_state       <= WAIT_HS;
                    end
                    WAIT_HS: begin
                        if (w_hs_fall || r_hs_pend) begin
                            r_hs_pend  <= w_hs_fall && r_hs_pend;
                            o_rd_addr  <= r_row;
                            o_rd_load  <= 1'b1;
                            r_out_line <= r_out_line + 1'b1;
                            r_state    <= LOAD;
                        end
                    end
                    LOAD: r_state <= STEP;
                    STEP: begin
                        if (w_adv && w_can_adv) r_src_line <= r_src_line + 1'b1;
                        if (w_step_done) begin
                            if (r_out_line == LINES) begin
                                o_line_active <= 1'b0;
                                r_state       <= IDLE;
                            end else begin
                                r_state       <= WAIT_HS;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath carries no reset: FRAME_INIT reloads it before any use
    always_ff @(posedge clk_vga) begin
        case (r_state)
            FRAME_INIT: begin
                r_row <= w_row_init;
`ifdef LFS_VZOOM_EN
                r_f   <= clamp_factor(i_scale_factor);
                r_acc <= '0;
`endif
            end
`ifdef LFS_VZOOM_EN
            LOAD: r_acc <= r_acc + ONE_Q17;
`endif
            STEP: begin
                if (w_adv) begin
`ifdef LFS_VZOOM_EN
                    r_acc <= r_acc - {1'b0, r_f};
`endif
                    if (w_can_adv) r_row <= r_row + HOR_SIZE_A;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Scoreboard bench for line_fetch_scheduler: expected load addresses are queued by
// the stimulus and popped by a monitor on every o_rd_load pulse.
module tb_line_fetch_scheduler;

    localparam int ADDR_W = 23;

    logic              clk_vga = 1'b0;
    logic              dly_rstn = 1'b0;
    logic              i_vs = 1'b1;
    logic              i_hs = 1'b1;
    logic [7:0]        i_scale_factor = 8'h80;
    logic [9:0]        i_x_offset = '0;
    logic [8:0]        i_y_offset = '0;
    logic [ADDR_W-1:0] i_base_addr = '0;
    logic [ADDR_W-1:0] o_rd_addr;
    logic              o_rd_load;
    logic              o_frame_start;
    logic [8:0]        o_src_line;
    logic              o_line_active;
    logic              o_hs_overrun;

    int                n_checks = 0;
    int                n_fail = 0;
    logic [ADDR_W-1:0] exp_q[$];
    bit                ignore_loads = 1'b0;

    always #5 clk_vga = ~clk_vga;

    line_fetch_scheduler dut (
        .clk_vga        (clk_vga),
        .dly_rstn       (dly_rstn),
        .i_vs           (i_vs),
        .i_hs           (i_hs),
        .i_scale_factor (i_scale_factor),
        .i_x_offset     (i_x_offset),
        .i_y_offset     (i_y_offset),
        .i_base_addr    (i_base_addr),
        .o_rd_addr      (o_rd_addr),
        .o_rd_load      (o_rd_load),
        .o_frame_start  (o_frame_start),
        .o_src_line     (o_src_line),
        .o_line_active  (o_line_active),
        .o_hs_overrun   (o_hs_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every load pulse must match the oldest queued expectation
    always @(negedge clk_vga) begin
        if (dly_rstn && o_rd_load && !ignore_loads) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_load: got addr %0d, expected no load (t=%0t)", o_rd_addr, $time);
            end else begin
                check("rd_addr", 32'(o_rd_addr), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    // VS low sampled at edge k; frame_start expected at k+2, line_active from k+3
    task automatic do_vs();
        @(posedge clk_vga); #1 i_vs = 1'b0;
        @(posedge clk_vga);
        @(posedge clk_vga);
        @(negedge clk_vga);
        check("frame_start_k1", 32'(o_frame_start), 32'd0);
        @(negedge clk_vga);
        check("frame_start_k2", 32'(o_frame_start), 32'd1);
        @(negedge clk_vga);
        check("frame_start_k3", 32'(o_frame_start), 32'd0);
        check("line_active_k3", 32'(o_line_active), 32'd1);
        i_vs = 1'b1;
        repeat (2) @(posedge clk_vga);
    endtask

    task automatic do_hs();
        @(posedge clk_vga); #1 i_hs = 1'b0;
        repeat (2) @(posedge clk_vga);
        #1 i_hs = 1'b1;
        repeat (8) @(posedge clk_vga);
    endtask

    task automatic line(input logic [ADDR_W-1:0] e);
        exp_q.push_back(e);
        do_hs();
    endtask

    // HS low sampled at edge a: load must appear at a+2, not a+1
    task automatic line_timed(input logic [ADDR_W-1:0] e);
        exp_q.push_back(e);
        @(posedge clk_vga); #1 i_hs = 1'b0;
        @(posedge clk_vga);
        @(posedge clk_vga);
        @(negedge clk_vga);
        check("rd_load_a1", 32'(o_rd_load), 32'd0);
        i_hs = 1'b1;
        @(negedge clk_vga);
        check("rd_load_a2", 32'(o_rd_load), 32'd1);
        repeat (8) @(posedge clk_vga);
    endtask

    task automatic set_params(input logic [7:0] f, input logic [9:0] x, input logic [8:0] y,
                              input logic [ADDR_W-1:0] b);
        i_scale_factor = f;
        i_x_offset     = x;
        i_y_offset     = y;
        i_base_addr    = b;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_vga);
        @(negedge clk_vga);
        check("rst_rd_addr", 32'(o_rd_addr), 32'd0);
        check("rst_rd_load", 32'(o_rd_load), 32'd0);
        check("rst_frame_start", 32'(o_frame_start), 32'd0);
        check("rst_src_line", 32'(o_src_line), 32'd0);
        check("rst_line_active", 32'(o_line_active), 32'd0);
        check("rst_hs_overrun", 32'(o_hs_overrun), 32'd0);
        dly_rstn = 1'b1;
        repeat (3) @(posedge clk_vga);

        // Full frame at unity zoom: 480 loads stepping by one line
        set_params(8'h80, 10'd0, 9'd0, 23'd0);
        do_vs();
        check("overrun_clear", 32'(o_hs_overrun), 32'd0);
        for (int i = 0; i < 480; i++) line(23'(i * 800));
        @(negedge clk_vga);
        check("frame_end_active", 32'(o_line_active), 32'd0);
        check("frame_end_src", 32'(o_src_line), 32'd479);
        do_hs();

        // x offset and base, then VS abort at line 100
        set_params(8'h80, 10'h180, 9'd0, 23'd1000);
        do_vs();
        line_timed(23'd1480);
        for (int i = 1; i < 100; i++) line(23'(1480 + i * 800));
        set_params(8'h80, 10'd0, 9'd2, 23'd5000);
        do_vs();
        line(23'd6600);
        line(23'd7400);

        // Back-to-back HS edges overrun the pending flag
        ignore_loads = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_vga); #1 i_hs = 1'b0;
            @(posedge clk_vga); #1 i_hs = 1'b1;
        end
        repeat (6) @(negedge clk_vga);
        check("overrun_set", 32'(o_hs_overrun), 32'd1);
        set_params(8'hFF, 10'd0, 9'd0, 23'd0);
        do_vs();
        check("overrun_cleared", 32'(o_hs_overrun), 32'd0);
        exp_q.delete();
        ignore_loads = 1'b0;

        // Zoom 0xFF (~2x, largest 8-bit factor)
`ifdef LFS_VZOOM_EN
        line(23'd0); line(23'd0); line(23'd800); line(23'd800); line(23'd1600);
`else
        line(23'd0); line(23'd800); line(23'd1600); line(23'd2400); line(23'd3200);
`endif

        // Zoom 0x40 (0.5x) and 0x10, which clamps to 0x40
        set_params(8'h40, 10'd0, 9'd0, 23'd0);
        do_vs();
`ifdef LFS_VZOOM_EN
        line(23'd0); line(23'd1600); line(23'd3200);
`else
        line(23'd0); line(23'd800); line(23'd1600);
`endif
        set_params(8'h10, 10'd0, 9'd0, 23'd0);
        do_vs();
`ifdef LFS_VZOOM_EN
        line(23'd0); line(23'd1600); line(23'd3200);
`else
        line(23'd0); line(23'd800); line(23'd1600);
`endif

        // y offset 470: source saturates at line 479 (address 383200)
        set_params(8'h80, 10'd0, 9'd470, 23'd0);
        do_vs();
        check("yoff_src_start", 32'(o_src_line), 32'd470);
        for (int i = 0; i < 14; i++) line(23'(376000 + ((i < 9) ? i : 9) * 800));
        check("yoff_src_sat", 32'(o_src_line), 32'd479);

        // Reset asserted mid-line, right after a load
        set_params(8'h80, 10'd0, 9'd0, 23'd0);
        do_vs();
        line(23'd0);
        line(23'd800);
        exp_q.push_back(23'd1600);
        @(posedge clk_vga); #1 i_hs = 1'b0;
        @(posedge clk_vga);
        @(posedge clk_vga); #1 i_hs = 1'b1;
        @(posedge clk_vga);
        @(negedge clk_vga);
        #1 dly_rstn = 1'b0;
        #1;
        check("midrst_rd_addr", 32'(o_rd_addr), 32'd0);
        check("midrst_rd_load", 32'(o_rd_load), 32'd0);
        check("midrst_src_line", 32'(o_src_line), 32'd0);
        check("midrst_line_active", 32'(o_line_active), 32'd0);
        check("midrst_frame_start", 32'(o_frame_start), 32'd0);
        @(negedge clk_vga);
        dly_rstn = 1'b1;
        do_hs();
        do_hs();
        check("postrst_active", 32'(o_line_active), 32'd0);
        set_params(8'h80, 10'd0, 9'd1, 23'd100);
        do_vs();
        line(23'd900);

        repeat (4) @(posedge clk_vga);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
